l2_noc3_msg_assembler: RTL and testbench
========================================

// Module: l2_noc3_msg_assembler
// PURPOSE
// - Upstream stage of the L2 pipe2 input path. Deserializes 64-bit NoC3 flits (memory/store acks, refill data) into one complete message.
// - Holds exactly one assembled message and offers it to pipe2 over a valid/ready handshake.
// - Backpressures NoC3 while a message is held. Flags messages whose payload overflows the buffer.
// PARAMETERS
// - MAX_PAYLOAD, default 3: payload flits stored per message (address flit + data flits); must be >= 1.
// - CNT_W, default 16: width of the delivered-message counter.
// PORTS
// - clk            in   1               clock
// - rst            in   1               synchronous, active-high reset
// - noc3_valid_in  in   1               flit valid
// - noc3_data_in   in   64              flit data
// - noc3_ready_in  out  1               flit accepted when valid && ready
// - msg_valid      out  1               assembled message available
// - msg_ready      in   1               pipe2 takes message when valid && ready
// - msg_type       out  8               header[21:14]
// - msg_mshrid     out  8               header[13:6]
// - msg_len        out  8               header[29:22], payload flit count as sent
// - msg_payload    out  MAX_PAYLOAD*64  payload flit i at bits [64*i+63:64*i]
// - msg_trunc      out  1               msg_len > MAX_PAYLOAD; extra flits dropped
// - msg_count      out  CNT_W           messages handed to pipe2, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; noc3_ready_in=1; msg_valid=0; msg_trunc=0; msg_count=0.
//   - msg_type, msg_mshrid, msg_len and msg_payload all 0.
//   - Reset mid-message discards all partial state; no flit is held across reset.
// - FSM: IDLE -> COLLECT -> HOLD -> IDLE.
//   - IDLE: a flit accepted here is the header.
//     - Latch type, mshrid and len; clear payload to 0; flit index idx=0.
//     - len==0: go to HOLD. len!=0: go to COLLECT.
//   - COLLECT: each accepted flit increments idx.
//     - idx < MAX_PAYLOAD: the flit is written to payload slot idx.
//     - idx >= MAX_PAYLOAD: the flit is dropped and msg_trunc is set.
//     - When the accepted flit has idx == len-1: go to HOLD.
//   - HOLD: msg_valid=1 and all msg_* outputs are stable.
//     - On msg_valid && msg_ready: go to IDLE and msg_count increments.
// - noc3_ready_in = (state != HOLD). It is a registered-state decode only, never combinational on msg_ready.
//   - So after a handshake, the next header is accepted no earlier than the following cycle.
// - Latency:
//   - msg_valid rises the cycle after the last flit is accepted (the header, when len==0).
//   - Minimum message period is len+2 cycles with msg_ready held high.
// - Payload slots at or above len remain 0.
// - len is 8 bits; idx is 8 bits and compared against len at full width, so len=255 collects 255 flits.
// - msg_valid never drops without a handshake. Outputs do not change while msg_valid && !msg_ready.
// - COLLECT stalls indefinitely on noc3_valid_in=0. There is no timeout.
// - msg_count wraps from 2^CNT_W-1 to 0 without any flag.
// TESTING
// - Reset, then header len=0 type=0x1A mshrid=0x05 -> next cycle msg_valid=1, msg_len=0, payload=0, trunc=0.
// - Header len=2 type=0x14, flits 0xA5A5..., 0x1234... with msg_ready=1:
//   - msg_valid 1 cycle after flit 2; slots0/1 = those flits; slot2=0; msg_count=1 after the handshake.
// - Header len=5 with MAX_PAYLOAD=3, flits 1..5:
//   - All 5 flits accepted (ready stays 1); payload = {3,2,1}; msg_trunc=1; msg_len=5.
// - Hold msg_ready=0 for 10 cycles in HOLD while noc3_valid_in=1:
//   - noc3_ready_in=0 throughout; outputs are stable; the handshake on cycle 11 makes ready=1 the next cycle.
// - Assert rst after 1 of 3 payload flits, then send a new len=1 message:
//   - Only the new message is delivered; no stale payload; msg_count=1.
// - Preload msg_count to 0xFFFF (CNT_W=16) via 65535 len=0 messages, then one more -> msg_count=0.

Source files
------------

// File: rtl/l2_noc3_msg_assembler.sv
// l2_noc3_msg_assembler
// Collects a NoC3 header flit plus its payload flits into one message and
// offers it to pipe2 on a valid/ready handshake. Payload flits beyond
// MAX_PAYLOAD are dropped and the message is flagged as truncated.
//
//   state   | meaning
//   IDLE    | waiting for a header flit
//   COLLECT | receiving payload flits, idx counts accepted flits
//   HOLD    | message complete, msg_valid high, NoC3 backpressured
module l2_noc3_msg_assembler #(
  parameter int MAX_PAYLOAD = 3,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      noc3_valid_in,
  input  logic [63:0]               noc3_data_in,
  output logic                      noc3_ready_in,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic [7:0]                msg_type,
  output logic [7:0]                msg_mshrid,
  output logic [7:0]                msg_len,
  output logic [MAX_PAYLOAD*64-1:0] msg_payload,
  output logic                      msg_trunc,
  output logic [CNT_W-1:0]          msg_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_idx;
  logic [7:0]                r_type;
  logic [7:0]                r_mshrid;
  logic [7:0]                r_len;
  logic [MAX_PAYLOAD*64-1:0] r_payload;
  logic                      r_trunc;
  logic [CNT_W-1:0]          r_count;
  logic                      w_accept;
  logic                      w_in_range;

  // Ready is a pure decode of the registered state so it never depends on msg_ready.
  assign noc3_ready_in = (r_state != HOLD);
  assign msg_valid     = (r_state == HOLD);
  assign w_accept      = noc3_valid_in && noc3_ready_in;
  assign w_in_range    = ({24'd0, r_idx} < 32'(MAX_PAYLOAD));

  assign msg_type    = r_type;
  assign msg_mshrid  = r_mshrid;
  assign msg_len     = r_len;
  assign msg_payload = r_payload;
  assign msg_trunc   = r_trunc;
  assign msg_count   = r_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; len is never 0 inside COLLECT so len-1 cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (noc3_data_in[29:22] == 8'd0) w_state_nxt = HOLD;
          else                             w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (w_accept && (r_idx == (r_len - 8'd1))) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (msg_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Header latch, payload capture with overflow drop, and delivered-message counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_type    <= '0;
      r_mshrid  <= '0;
      r_len     <= '0;
      r_payload <= '0;
      r_trunc   <= 1'b0;
      r_count   <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_type    <= noc3_data_in[21:14];
        r_mshrid  <= noc3_data_in[13:6];
        r_len     <= noc3_data_in[29:22];
        r_payload <= '0;
        r_idx     <= '0;
        r_trunc   <= 1'b0;
      end
      if (r_state == COLLECT && w_accept) begin
        r_idx <= r_idx + 8'd1;
        if (w_in_range) begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (32'(r_idx) == i) r_payload[64*i +: 64] <= noc3_data_in;
          end
        end else begin
          r_trunc <= 1'b1;
        end
      end
      if (msg_valid && msg_ready) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l2_noc3_msg_assembler.sv
// Testbench for l2_noc3_msg_assembler. A message-level model (flit queue in,
// expected payload/len/trunc/count out) predicts every observed value.
// The counter is built 8 bits wide so its wrap is reachable in a short run.
module tb_l2_noc3_msg_assembler;
  localparam int MAXP = 3;
  localparam int CW   = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                noc3_valid_in;
  logic [63:0]         noc3_data_in;
  logic                noc3_ready_in;
  logic                msg_valid;
  logic                msg_ready;
  logic [7:0]          msg_type;
  logic [7:0]          msg_mshrid;
  logic [7:0]          msg_len;
  logic [MAXP*64-1:0]  msg_payload;
  logic                msg_trunc;
  logic [CW-1:0]       msg_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  l2_noc3_msg_assembler #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .noc3_valid_in(noc3_valid_in), .noc3_data_in(noc3_data_in), .noc3_ready_in(noc3_ready_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_type(msg_type), .msg_mshrid(msg_mshrid), .msg_len(msg_len),
    .msg_payload(msg_payload), .msg_trunc(msg_trunc), .msg_count(msg_count)
  );

  // Present one flit, wait (bounded) for ready, let it be accepted; reports cycles waited.
  task automatic drive_flit(input logic [63:0] d, output int waited);
    waited = 0;
    noc3_valid_in = 1'b1;
    noc3_data_in  = d;
    while (noc3_ready_in !== 1'b1 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (waited >= 300) begin
      failures++;
      $display("FAIL flit_timeout: ready=%b required 1 within 300 cycles", noc3_ready_in);
    end
    @(posedge clk); #1;
    noc3_valid_in = 1'b0;
  endtask

  task automatic check_msg(input string tag, input int len, input logic [7:0] t,
                           input logic [7:0] m, input logic [MAXP*64-1:0] pl);
    checks++;
    if (msg_valid !== 1'b1 || noc3_ready_in !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid: valid=%b ready=%b required valid=1 ready=0", tag, msg_valid, noc3_ready_in);
    end
    checks++;
    if (msg_len !== 8'(len) || msg_type !== t || msg_mshrid !== m) begin
      failures++;
      $display("FAIL %s_hdr: len=%h type=%h mshrid=%h required %h %h %h", tag, msg_len, msg_type, msg_mshrid, 8'(len), t, m);
    end
    checks++;
    if (msg_payload !== pl) begin
      failures++;
      $display("FAIL %s_payload: got %h required %h", tag, msg_payload, pl);
    end
    checks++;
    if (msg_trunc !== (len > MAXP)) begin
      failures++;
      $display("FAIL %s_trunc: got %b required %b", tag, msg_trunc, (len > MAXP));
    end
  endtask

  // One complete message. exp_wait<0 skips the header-wait check; b2b leaves
  // msg_ready held high so the handshake happens while the next header waits.
  task automatic do_msg(input string tag, input logic [7:0] t, input logic [7:0] m,
                        input logic [63:0] fl[$], input int hold, input bit b2b,
                        input bit gaps, input int exp_wait);
    logic [63:0]        hdr;
    logic [MAXP*64-1:0] pl;
    int                 len;
    int                 w;
    len = fl.size();
    hdr = {$urandom, $urandom};
    hdr[29:22] = 8'(len);
    hdr[21:14] = t;
    hdr[13:6]  = m;
    pl = '0;
    for (int i = 0; i < len && i < MAXP; i++) pl[64*i +: 64] = fl[i];
    drive_flit(hdr, w);
    if (exp_wait >= 0) begin
      checks++;
      if (w != exp_wait) begin
        failures++;
        $display("FAIL %s_hdr_wait: waited %0d cycles required %0d", tag, w, exp_wait);
      end
    end
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        checks++;
        if (msg_valid !== 1'b0 || noc3_ready_in !== 1'b1) begin
          failures++;
          $display("FAIL %s_stall: valid=%b ready=%b required 0 1", tag, msg_valid, noc3_ready_in);
        end
      end
      drive_flit(fl[i], w);
      checks++;
      if (w != 0) begin
        failures++;
        $display("FAIL %s_collect_ready: payload flit %0d waited %0d required 0", tag, i, w);
      end
    end
    check_msg(tag, len, t, m, pl);
    if (!b2b) begin
      noc3_valid_in = 1'b1;
      for (int c = 0; c < hold; c++) begin
        noc3_data_in = {$urandom, $urandom};
        @(posedge clk); #1;
        check_msg({tag, "_hold"}, len, t, m, pl);
      end
      noc3_valid_in = 1'b0;
      msg_ready = 1'b1;
      @(posedge clk); #1;
      msg_ready = 1'b0;
      exp_count++;
      checks++;
      if (msg_valid !== 1'b0 || noc3_ready_in !== 1'b1 || msg_count !== CW'(exp_count)) begin
        failures++;
        $display("FAIL %s_handshake: valid=%b ready=%b count=%0d required 0 1 %0d", tag, msg_valid, noc3_ready_in, msg_count, CW'(exp_count));
      end
    end else begin
      exp_count++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (noc3_ready_in !== 1'b1 || msg_valid !== 1'b0 || msg_trunc !== 1'b0 || msg_count !== '0 ||
        msg_type !== 8'h0 || msg_mshrid !== 8'h0 || msg_len !== 8'h0 || msg_payload !== '0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b trunc=%b count=%0d type=%h mshrid=%h len=%h payload=%h required 1 0 0 0 0 0 0 0",
               noc3_ready_in, msg_valid, msg_trunc, msg_count, msg_type, msg_mshrid, msg_len, msg_payload);
    end
  endtask

  task automatic test_len0;
    logic [63:0] q[$];
    q = {};
    do_msg("len0", 8'h1A, 8'h05, q, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_len2;
    logic [63:0] q[$];
    q = {64'hA5A5_A5A5_A5A5_A5A5, 64'h1234_5678_9ABC_DEF0};
    do_msg("len2", 8'h14, 8'h33, q, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_trunc;
    logic [63:0] q[$];
    q = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    do_msg("trunc", 8'h22, 8'h44, q, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    logic [63:0] q[$];
    q = {64'hDEAD_BEEF_0000_0001};
    do_msg("bp", 8'h07, 8'h09, q, 10, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_message;
    logic [63:0] hdr;
    logic [63:0] q[$];
    int          w;
    hdr = 64'h0;
    hdr[29:22] = 8'd3;
    hdr[21:14] = 8'h55;
    drive_flit(hdr, w);
    drive_flit(64'hBAD0_BAD0_BAD0_BAD0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
    test_reset();
    q = {64'h0123_4567_89AB_CDEF};
    do_msg("post_rst", 8'h31, 8'h41, q, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [63:0] q[$];
    int          len;
    for (int n = 0; n < 25; n++) begin
      q = {};
      len = (n == 12) ? 255 : $urandom_range(0, 6);
      for (int i = 0; i < len; i++) q.push_back({$urandom, $urandom});
      do_msg("rand", 8'($urandom), 8'($urandom), q, $urandom_range(0, 3), 1'b0, 1'b1, 0);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] q[$];
    int          len;
    msg_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      q = {};
      len = $urandom_range(0, 4);
      for (int i = 0; i < len; i++) q.push_back({$urandom, $urandom});
      do_msg("b2b", 8'($urandom), 8'($urandom), q, 0, 1'b1, 1'b0, (n == 0) ? 0 : 1);
    end
    @(posedge clk); #1;
    msg_ready = 1'b0;
    checks++;
    if (msg_valid !== 1'b0 || msg_count !== CW'(exp_count)) begin
      failures++;
      $display("FAIL b2b_end: valid=%b count=%0d required 0 %0d", msg_valid, msg_count, CW'(exp_count));
    end
  endtask

  task automatic test_count_wrap;
    logic [63:0] q[$];
    q = {};
    msg_ready = 1'b1;
    while (exp_count % (1 << CW) != 0) begin
      do_msg("wrap", 8'h00, 8'h00, q, 0, 1'b1, 1'b0, -1);
    end
    @(posedge clk); #1;
    msg_ready = 1'b0;
    checks++;
    if (msg_count !== '0) begin
      failures++;
      $display("FAIL count_wrap: count=%0d required 0", msg_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    noc3_valid_in = 1'b0;
    noc3_data_in  = '0;
    msg_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_len0();
    test_len2();
    test_trunc();
    test_backpressure();
    test_reset_mid_message();
    test_random();
    test_back_to_back();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
